// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch front end. Owns the fetch PC, keeps at most one
//   instruction-memory read in flight, and parks each returned word in a
//   single-entry output register until the instruction queue takes it.
//   Conditional branches with a negative offset are predicted taken; every
//   other instruction, including JAL/JALR, is fetched sequentially and left
//   for branch resolution to correct through a redirect.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_addr   [31:0]    read address, always the fetch PC
//   imem_rmask  [3:0]     4'hf in the single cycle a request issues
//   imem_rdata  [31:0]    read data, qualified by imem_resp
//   imem_resp             one-cycle response pulse
//   redirect_valid        one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc [31:0]    redirect target (word aligned)
//   fetch_ready           instruction queue can accept
//   fetch_valid           output register holds an instruction
//   fetch_inst  [31:0]    instruction word
//   fetch_pc    [31:0]    address of fetch_inst
//   fetch_predict_branch  fetch_inst was predicted taken
//   state_dbg   [1:0]     FSM state (0 idle, 1 wait, 2 discard)
//
// Handshakes
//   Queue side: an instruction moves to the queue on a cycle where
//   fetch_valid and fetch_ready are both 1. fetch_valid never drops and the
//   fetch_* payload never changes while the register is full and not yet
//   accepted, except when a redirect flushes it.
//   Memory side: a request is the single cycle with imem_rmask=4'hf; the
//   memory answers later with exactly one imem_resp pulse. No second request
//   issues until that response has been seen.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_inst,
  output logic [31:0] fetch_pc,
  output logic        fetch_predict_branch,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;

  logic        issue;
  logic        transfer;
  logic        is_bwd_branch;
  logic [31:0] b_imm;
  logic [31:0] next_pc;

  assign transfer = fetch_valid & fetch_ready;

  // A request may only go out when its response is guaranteed a free output
  // register: either the register is empty or it drains this cycle. rst_n
  // keeps the strobe quiet while reset is held, since the state already
  // reads IDLE then.
  assign issue = rst_n & (state == S_IDLE) & ~redirect_valid &
                 (~fetch_valid | fetch_ready);

  assign imem_addr  = pc;
  assign imem_rmask = issue ? 4'hf : 4'h0;
  assign state_dbg  = state;

  // B-type immediate; bit 31 of the word is the sign, so a set bit 31 on a
  // conditional branch means a backward target.
  assign b_imm = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                  imem_rdata[11:8], 1'b0};
  assign is_bwd_branch = (imem_rdata[6:0] == 7'b1100011) & imem_rdata[31];
  assign next_pc = is_bwd_branch ? (pc + b_imm) : (pc + 32'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      pc                   <= RESET_PC;
      fetch_valid          <= 1'b0;
      fetch_inst           <= 32'h0;
      fetch_pc             <= 32'h0;
      fetch_predict_branch <= 1'b0;
    end else if (redirect_valid) begin
      // Flush wins over everything else this cycle. A response that is still
      // on its way becomes stale and must be swallowed in DISCARD; one that
      // arrives right now is simply dropped.
      pc          <= redirect_pc;
      fetch_valid <= 1'b0;
      if (state == S_WAIT) begin
        state <= imem_resp ? S_IDLE : S_DISCARD;
      end
    end else begin
      if (transfer) begin
        fetch_valid <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          // A response here has no request behind it and is ignored.
          if (issue) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp) begin
            // Overrides the drain above: the slot freed by a same-cycle
            // transfer is refilled on this edge.
            fetch_valid          <= 1'b1;
            fetch_inst           <= imem_rdata;
            fetch_pc             <= pc;
            fetch_predict_branch <= is_bwd_branch;
            pc                   <= next_pc;
            state                <= S_IDLE;
          end
        end
        S_DISCARD: begin
          if (imem_resp) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
